maze_player_ctrl: RTL and testbench

Sequencing controller that owns the player state fed to the maze renderer. Turns debounced direction buttons into legal tile moves checked against `path_data`, and applies moves only at frame boundaries so the renderer never tears mid-frame. Derives the scroll origin (`x_coord`, `y_coord`) for mazes larger than the screen, and flags arrival at the finish tile. Sits between the button/debounce front end and the renderer; its outputs drive the renderer's `char_x`, `char_y`, `x_coord` and `y_coord` inputs directly.

---
 rtl/maze_pkg.sv | 21 ++
 rtl/maze_player_ctrl_btn_edge.sv | 22 ++
 rtl/maze_player_ctrl.sv | 177 +++++++++++++++++
 tb/tb_maze_player_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze game: grid size, screen size, direction and
// controller state encodings. The renderer imports the same screen constants.
package maze_pkg;

    localparam int MAZE_DIM = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PLAY   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SCROLL = 3'd3;
    localparam logic [2:0] ST_WON    = 3'd4;

endpackage

// File: rtl/maze_player_ctrl_btn_edge.sv
// Registered rising-edge detector for the four direction buttons.
// Bit order: 0 = up, 1 = down, 2 = left, 3 = right.
module btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] rise
);

    logic [3:0] btn_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Player controller: captures button edges, applies one tile move per frame at
// vertical blanking, recomputes the scroll origin and flags the finish tile.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int MAZE_DIM = maze_pkg::MAZE_DIM,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         frame_tick,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic [MAZE_DIM*MAZE_DIM-1:0] path_data,
    input  logic [4:0]                   maze_width,
    input  logic [4:0]                   maze_height,
    input  logic [4:0]                   tile_width,
    input  logic [4:0]                   tile_height,
    input  logic [4:0]                   start_x,
    input  logic [4:0]                   start_y,
    input  logic [4:0]                   finish_x,
    input  logic [4:0]                   finish_y,
    output logic [6:0]                   char_x,
    output logic [6:0]                   char_y,
    output logic [4:0]                   x_coord,
    output logic [4:0]                   y_coord,
    output logic                         won,
    output logic                         move_ok,
    output logic                         bump,
    output logic [CNT_W-1:0]             move_count,
    output logic [2:0]                   dbg_state
);

    localparam int IDX_W = $clog2(MAZE_DIM * MAZE_DIM);

    // load and frame_tick are single-cycle strobes with no back-pressure;
    // move_ok and bump are single-cycle result strobes, valid with char_* updated.

    logic [2:0]  state;
    logic [2:0]  pending;
    logic [2:0]  new_dir;
    logic [3:0]  rise;
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic signed [5:0] tx;
    logic signed [5:0] ty;
    logic [IDX_W-1:0]  tgt_idx;
    logic        in_range;
    logic        legal;
    logic [9:0]  vis_x;
    logic [9:0]  vis_y;
    logic [4:0]  vp_x;
    logic [4:0]  vp_y;

    assign char_x    = {2'b00, cx};
    assign char_y    = {2'b00, cy};
    assign dbg_state = state;

    btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   ({btn_right, btn_left, btn_down, btn_up}),
        .rise  (rise)
    );

    always_comb begin
        new_dir = DIR_NONE;
        if (rise[0])      new_dir = DIR_UP;
        else if (rise[1]) new_dir = DIR_DOWN;
        else if (rise[2]) new_dir = DIR_LEFT;
        else if (rise[3]) new_dir = DIR_RIGHT;
    end

    // Target computed in 6-bit signed so a step off either edge shows up as out of range.
    always_comb begin
        tx = signed'({1'b0, cx});
        ty = signed'({1'b0, cy});
        case (pending)
            DIR_UP:    ty = ty - 6'sd1;
            DIR_DOWN:  ty = ty + 6'sd1;
            DIR_LEFT:  tx = tx - 6'sd1;
            DIR_RIGHT: tx = tx + 6'sd1;
            default: ;
        endcase
        in_range = (tx >= 6'sd0) && (tx < signed'({1'b0, maze_width})) &&
                   (ty >= 6'sd0) && (ty < signed'({1'b0, maze_height}));
        tgt_idx  = IDX_W'(tx[4:0]) + IDX_W'(MAZE_DIM) * IDX_W'(ty[4:0]);
        legal    = in_range && path_data[tgt_idx];
    end

    function automatic logic [4:0] clamp_axis(input logic [4:0] pos,
                                              input logic [4:0] size,
                                              input logic [9:0] vis);
        logic signed [11:0] lo;
        logic signed [11:0] hi;
        clamp_axis = '0;
        if ({5'b00000, size} > vis) begin
            lo = signed'({7'b0, pos}) - signed'({3'b0, vis[9:1]});
            hi = signed'({7'b0, size}) - signed'({2'b0, vis});
            if (lo < 12'sd0)   clamp_axis = '0;
            else if (lo > hi)  clamp_axis = hi[4:0];
            else               clamp_axis = lo[4:0];
        end
    endfunction

    always_comb begin
        vis_x = 10'(SCREEN_W >> tile_width);
        vis_y = 10'(SCREEN_H >> tile_height);
        vp_x  = clamp_axis(cx, maze_width, vis_x);
        vp_y  = clamp_axis(cy, maze_height, vis_y);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pending    <= DIR_NONE;
            cx         <= '0;
            cy         <= '0;
            x_coord    <= '0;
            y_coord    <= '0;
            won        <= 1'b0;
            move_ok    <= 1'b0;
            bump       <= 1'b0;
            move_count <= '0;
        end else begin
            move_ok <= 1'b0;
            bump    <= 1'b0;
            if (load) begin
                state      <= ST_SCROLL;
                cx         <= start_x;
                cy         <= start_y;
                move_count <= '0;
                won        <= 1'b0;
                pending    <= DIR_NONE;
            end else begin
                // Only one move may wait; edges arriving behind it are dropped.
                if ((state == ST_PLAY || state == ST_SCROLL) && pending == DIR_NONE) begin
                    pending <= new_dir;
                end
                case (state)
                    ST_IDLE: ;
                    ST_PLAY: begin
                        if (frame_tick && pending != DIR_NONE) state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (legal) begin
                            cx      <= tx[4:0];
                            cy      <= ty[4:0];
                            move_ok <= 1'b1;
                            if (move_count != '1) move_count <= move_count + CNT_W'(1);
                        end else begin
                            bump <= 1'b1;
                        end
                        pending <= DIR_NONE;
                        state   <= ST_SCROLL;
                    end
                    ST_SCROLL: begin
                        x_coord <= vp_x;
                        y_coord <= vp_y;
                        if (cx == finish_x && cy == finish_y) begin
                            won   <= 1'b1;
                            state <= ST_WON;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end
                    ST_WON:  won   <= 1'b1;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl: expected move results are queued as
// stimulus is issued and a negedge monitor pops them on every move_ok/bump.
module tb_maze_player_ctrl;
    import maze_pkg::*;

    localparam int EW = 27;
    localparam logic [3:0] B_UP    = 4'b0001;
    localparam logic [3:0] B_DOWN  = 4'b0010;
    localparam logic [3:0] B_LEFT  = 4'b0100;
    localparam logic [3:0] B_RIGHT = 4'b1000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic         frame_tick = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [255:0] path_data;
    logic [4:0]   maze_width = 5'd16, maze_height = 5'd16;
    logic [4:0]   tile_width = 5'd5, tile_height = 5'd5;
    logic [4:0]   start_x = 5'd1, start_y = 5'd1, finish_x = 5'd15, finish_y = 5'd0;
    logic [6:0]   char_x, char_y;
    logic [4:0]   x_coord, y_coord;
    logic         won, move_ok, bump;
    logic [15:0]  move_count;
    logic [2:0]   dbg_state;

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_act;
    logic [EW-1:0] mon_exp;

    maze_player_ctrl #(.MAZE_DIM(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .load(load), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
        .tile_width(tile_width), .tile_height(tile_height),
        .start_x(start_x), .start_y(start_y), .finish_x(finish_x), .finish_y(finish_y),
        .char_x(char_x), .char_y(char_y), .x_coord(x_coord), .y_coord(y_coord),
        .won(won), .move_ok(move_ok), .bump(bump), .move_count(move_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic ok, input logic [4:0] x, input logic [4:0] y,
                            input logic [15:0] cnt);
        exp_q.push_back({ok, x, y, cnt});
    endtask

    // Monitor: every result strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (move_ok || bump)) begin
            mon_act = {move_ok, char_x[4:0], char_y[4:0], move_count};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got ok=%0b bump=%0b pos=(%0d,%0d) required no result",
                         move_ok, bump, char_x, char_y);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp || (move_ok && bump)) begin
                    bad++;
                    $display("FAIL move_result: got ok=%0b bump=%0b pos=(%0d,%0d) cnt=%0d required ok=%0b pos=(%0d,%0d) cnt=%0d",
                             move_ok, bump, char_x, char_y, move_count,
                             mon_exp[26], mon_exp[25:21], mon_exp[20:16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic set_btn(input logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic press(input logic [3:0] b);
        @(posedge clk); #1 set_btn(b);
        repeat (2) @(posedge clk);
        #1 set_btn(4'b0000);
    endtask

    task automatic frame();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic mv(input logic [3:0] b, input logic ok, input int x, input int y, input int cnt);
        push_exp(ok, 5'(x), 5'(y), 16'(cnt));
        press(b);
        frame();
    endtask

    task automatic do_load(input logic [4:0] sx, input logic [4:0] sy, input logic exp_won);
        @(posedge clk); #1 start_x = sx; start_y = sy; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        check("load_char_x", int'(char_x), int'(sx));
        check("load_char_y", int'(char_y), int'(sy));
        check("load_count", int'(move_count), 0);
        check("load_won_t1", int'(won), 0);
        @(negedge clk);
        check("load_won_t2", int'(won), int'(exp_won));
        check("load_x_coord", int'(x_coord), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_char_x"}, int'(char_x), 0);
        check({tag, "_char_y"}, int'(char_y), 0);
        check({tag, "_x_coord"}, int'(x_coord), 0);
        check({tag, "_y_coord"}, int'(y_coord), 0);
        check({tag, "_won"}, int'(won), 0);
        check({tag, "_move_ok"}, int'(move_ok), 0);
        check({tag, "_bump"}, int'(bump), 0);
        check({tag, "_count"}, int'(move_count), 0);
        check({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
    endtask

    initial begin
        path_data = '0;
        path_data[31:16] = '1;
        path_data[15] = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        // IDLE ignores buttons
        press(B_RIGHT);
        frame();
        check("idle_char_x", int'(char_x), 0);

        // Basic move, walls and edges
        do_load(5'd1, 5'd1, 1'b0);
        mv(B_RIGHT, 1'b1, 2, 1, 1);
        check("basic_count", int'(move_count), 1);
        mv(B_LEFT,  1'b1, 1, 1, 2);
        mv(B_UP,    1'b0, 1, 1, 2);
        mv(B_LEFT,  1'b1, 0, 1, 3);
        mv(B_LEFT,  1'b0, 0, 1, 3);

        // Up beats right in the same cycle; a second press before the tick is dropped
        mv(B_UP | B_RIGHT, 1'b0, 0, 1, 3);
        push_exp(1'b1, 5'd1, 5'd1, 16'd4);
        press(B_RIGHT);
        press(B_DOWN);
        frame();
        frame();
        check("dropped_char_y", int'(char_y), 1);

        // Scrolling with a 10-tile-wide viewport
        tile_width = 5'd6;
        for (int i = 2; i <= 8; i++) mv(B_RIGHT, 1'b1, i, 1, i + 3);
        @(negedge clk);
        check("scroll_x8", int'(x_coord), 3);
        for (int i = 9; i <= 12; i++) mv(B_RIGHT, 1'b1, i, 1, i + 3);
        @(negedge clk);
        check("scroll_x12", int'(x_coord), 6);
        for (int i = 13; i <= 15; i++) mv(B_RIGHT, 1'b1, i, 1, i + 3);
        @(negedge clk);
        check("scroll_x15", int'(x_coord), 6);
        mv(B_RIGHT, 1'b0, 15, 1, 18);
        check("scroll_y", int'(y_coord), 0);
        tile_width = 5'd5;
        mv(B_LEFT, 1'b1, 14, 1, 19);
        @(negedge clk);
        check("scroll_wide", int'(x_coord), 0);
        mv(B_RIGHT, 1'b1, 15, 1, 20);

        // Reach the finish: won appears one edge after the char update
        push_exp(1'b1, 5'd15, 5'd0, 16'd21);
        press(B_UP);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("won_t2_char_y", int'(char_y), 0);
        check("won_t2", int'(won), 0);
        @(negedge clk);
        check("won_t3", int'(won), 1);
        check("won_state", int'(dbg_state), int'(ST_WON));
        press(B_DOWN);
        frame();
        check("won_hold_char_y", int'(char_y), 0);
        check("won_hold", int'(won), 1);
        check("won_hold_count", int'(move_count), 21);

        // Reload clears won; start on finish wins immediately
        do_load(5'd1, 5'd1, 1'b0);
        finish_x = 5'd1; finish_y = 5'd1;
        do_load(5'd1, 5'd1, 1'b1);
        finish_x = 5'd15; finish_y = 5'd0;

        // Async reset while CHECK is active
        do_load(5'd1, 5'd1, 1'b0);
        mv(B_RIGHT, 1'b1, 2, 1, 1);
        press(B_RIGHT);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        check("pre_reset_state", int'(dbg_state), int'(ST_CHECK));
        #1 reset = 1'b0;
        #1 check_zero("async");
        @(posedge clk); #1 reset = 1'b1;

        // Load wins over frame_tick and a pending move
        do_load(5'd1, 5'd1, 1'b0);
        press(B_RIGHT);
        @(posedge clk); #1 start_x = 5'd3; load = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1 load = 1'b0; frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("prio_char_x", int'(char_x), 3);
        check("prio_count", int'(move_count), 0);
        frame();
        check("prio_no_move", int'(char_x), 3);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
